// File: rtl/spi_master_nx.sv
// spi_master_nx: SPI master with configurable width, CPOL/CPHA, bit order, NUM_SS selects.
// Optional internal loopback on CTRL bit3 when SPI_LOOPBACK_EN is defined.
module spi_master_nx #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              wr,
   input  logic              rd,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n
);
   localparam int BW = $clog2(DATA_W);
   localparam logic [BW:0] LAST_TOG = (BW+1)'(2*DATA_W-1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W-1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state;
   logic [DIV_W-1:0]  clk_div, div_l, cnt;
   logic              cpha, cpol, lsbf;
   logic              cpha_l, cpol_l, lsbf_l;
   logic [3:0]        ss_idx;
   logic [DATA_W-1:0] tx_shift, rx_shift, rx_data;
   logic [BW:0]       tog;
   logic              busy, done, wcol;
   logic [NUM_SS-1:0] ss_dec;
   logic              wr_en, rd_en, tick, s_bit;
   logic [BW-1:0]     bitn, nbit;

`ifdef SPI_LOOPBACK_EN
   logic loop_en, loop_l;
   assign s_bit = loop_l ? mosi : miso;
`else
   logic loop_en;
   assign loop_en = 1'b0;
   assign s_bit = miso;
`endif

   assign wr_en = cs && wr;
   assign rd_en = cs && rd;
   assign tick  = (cnt == div_l);
   assign bitn  = tog[BW:1];
   assign nbit  = bitn + 1'b1;

   // wire position of the n-th transmitted bit for the chosen order
   function automatic logic [BW-1:0] bpos(input logic lsb, input logic [BW-1:0] n);
      return lsb ? n : LAST_BIT - n;
   endfunction

   // one-hot low select; out-of-range index leaves every line high
   always_comb begin
      ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (ss_idx == 4'(i)) ss_dec[i] = 1'b0;
   end

   // register read mux; zero unless a read strobe is present
   always_comb begin
      out_data = '0;
      if (rd_en) begin
         case (addr)
            2'b00:   out_data = rx_data;
            2'b01:   out_data[2:0] = {wcol, done, busy};
            2'b10:   out_data[DIV_W-1:0] = clk_div;
            default: out_data[7:0] = {ss_idx, loop_en, lsbf, cpol, cpha};
         endcase
      end
   end

   // register file, transfer FSM and shifter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         clk_div  <= '0;
         div_l    <= '0;
         cnt      <= '0;
         cpha     <= 1'b0;
         cpol     <= 1'b0;
         lsbf     <= 1'b0;
         cpha_l   <= 1'b0;
         cpol_l   <= 1'b0;
         lsbf_l   <= 1'b0;
         ss_idx   <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         tog      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wcol     <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= '1;
`ifdef SPI_LOOPBACK_EN
         loop_en  <= 1'b0;
         loop_l   <= 1'b0;
`endif
      end else begin
         if (rd_en && addr == 2'b01) wcol <= 1'b0;
         if (rd_en && addr == 2'b00) done <= 1'b0;
         if (wr_en && busy && addr != 2'b01) wcol <= 1'b1;
         if (state != IDLE) cnt <= tick ? '0 : cnt + 1'b1;
         unique case (state)
            IDLE: begin
               sclk <= cpol;
               ss_n <= '1;
               if (wr_en) begin
                  case (addr)
                     2'b00: begin
                        tx_shift <= in_data;
                        state    <= SETUP;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        ss_n     <= ss_dec;
                        cnt      <= '0;
                        tog      <= '0;
                        div_l    <= clk_div;
                        cpha_l   <= cpha;
                        cpol_l   <= cpol;
                        lsbf_l   <= lsbf;
`ifdef SPI_LOOPBACK_EN
                        loop_l   <= loop_en;
`endif
                        if (!cpha) mosi <= in_data[bpos(lsbf, BW'(0))];
                     end
                     2'b10: clk_div <= in_data[DIV_W-1:0];
                     2'b11: begin
                        cpha   <= in_data[0];
                        cpol   <= in_data[1];
                        lsbf   <= in_data[2];
                        ss_idx <= in_data[7:4];
`ifdef SPI_LOOPBACK_EN
                        loop_en <= in_data[3];
`endif
                     end
                     default: ;
                  endcase
               end
            end
            SETUP: if (tick) state <= SHIFT;
            SHIFT: if (tick) begin
               sclk <= ~sclk;
               tog  <= tog + 1'b1;
               if (!tog[0]) begin
                  if (!cpha_l) rx_shift[bpos(lsbf_l, bitn)] <= s_bit;
                  else         mosi <= tx_shift[bpos(lsbf_l, bitn)];
               end else begin
                  if (cpha_l) rx_shift[bpos(lsbf_l, bitn)] <= s_bit;
                  else if (bitn != LAST_BIT)
                     mosi <= tx_shift[bpos(lsbf_l, nbit)];
               end
               if (tog == LAST_TOG) begin
                  sclk  <= cpol_l;
                  state <= HOLD;
               end
            end
            HOLD: if (tick) begin
               rx_data <= rx_shift;
               ss_n    <= '1;
               busy    <= 1'b0;
               done    <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_nx.sv
// tb_spi_master_nx: vector table plus hand sequences, with a slave model
// and a queue of expected transfer results.
module tb_spi_master_nx;
   localparam int W = 8;

   logic         clk = 1'b0, rst = 1'b1;
   logic         cs = 1'b0, wr = 1'b0, rd = 1'b0, miso = 1'b0;
   logic [1:0]   addr = 2'b00;
   logic [W-1:0] in_data = '0;
   logic [W-1:0] out_data;
   logic         sclk, mosi;
   logic [3:0]   ss_n;

   always #5 clk = ~clk;

   spi_master_nx #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
      .in_data(in_data), .out_data(out_data), .sclk(sclk), .mosi(mosi),
      .miso(miso), .ss_n(ss_n)
   );

   typedef struct {
      logic       cpol, cpha, lsbf;
      logic [3:0] idx;
      logic [7:0] div, tx, slv;
      logic [3:0] ss;
      int         busy;
   } vec_t;

   typedef struct {
      logic [7:0] rx, mw;
      logic [3:0] ss;
      int         busy, tog;
      logic       cpol;
   } exp_t;

   exp_t sbq[$];
   vec_t vt[5];
   int   checks = 0, errors = 0;

   logic       s_en = 1'b0, s_cpha = 1'b0, s_lsbf = 1'b0;
   logic [7:0] s_word = '0, s_mrx = '0;
   int         s_e = 0;

   function automatic int bix(input logic lsb, input int n);
      return lsb ? n : W - 1 - n;
   endfunction

   // slave: captures mosi on sampling edges, shifts miso on the others
   always @(sclk) begin
      int n;
      if (s_en) begin
         n = s_e / 2;
         if (s_e[0] == s_cpha) s_mrx[bix(s_lsbf, n)] = mosi;
         if (!s_cpha && s_e[0] && n + 1 < W) miso = s_word[bix(s_lsbf, n + 1)];
         if (s_cpha && !s_e[0]) miso = s_word[bix(s_lsbf, n)];
         s_e++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; in_data = d;
      @(posedge clk); #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      #1 d = out_data;
      @(posedge clk); #1;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic start(input vec_t v, input logic lp);
      exp_t e;
      wr_reg(2'b11, {v.idx, lp, v.lsbf, v.cpol, v.cpha});
      wr_reg(2'b10, v.div);
      s_cpha = v.cpha; s_lsbf = v.lsbf; s_word = v.slv;
      s_mrx = '0; s_e = 0;
      miso = v.slv[bix(v.lsbf, 0)];
      s_en = 1'b1;
      e.rx = lp ? v.tx : v.slv;
      e.mw = v.tx; e.ss = v.ss; e.busy = v.busy;
      e.tog = 2 * W; e.cpol = v.cpol;
      sbq.push_back(e);
      wr_reg(2'b00, v.tx);
   endtask

   task automatic finish_xfer(input int skip);
      exp_t e;
      int   bc, tg;
      logic ssbad, pv, ok;
      logic [7:0] d;
      bc = 0; tg = 0; ssbad = 1'b0; ok = 1'b0;
      if (sbq.size() == 0) begin
         errors++; checks++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sbq.pop_front();
      pv = sclk;
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 2'b01;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!out_data[0]) begin ok = 1'b1; break; end
         bc++;
         if (ss_n !== e.ss) ssbad = 1'b1;
         if (sclk !== pv) begin tg++; pv = sclk; end
      end
      cs = 1'b0; rd = 1'b0; s_en = 1'b0;
      chk("xfer_done_in_time", ok, 1);
      chk("busy_cycles", bc + skip, e.busy);
      chk("ss_n_during", ssbad, 0);
      chk("sclk_toggles", tg, e.tog);
      chk("mosi_word", s_mrx, e.mw);
      chk("sclk_idle", sclk, e.cpol);
      chk("ss_n_idle", ss_n, 4'hF);
      rd_reg(2'b01, d); chk("status_done", d, 8'h02);
      rd_reg(2'b00, d); chk("rx_data", d, e.rx);
      rd_reg(2'b01, d); chk("status_cleared", d, 8'h00);
   endtask

   initial begin
      logic [7:0] d;
      logic pv;
      int n;
      vec_t w;
      vt[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'hA5, 8'h3C, 4'b1110, 18};
      vt[1] = '{1'b1, 1'b1, 1'b1, 4'd2, 8'd3, 8'h81, 8'h5A, 4'b1011, 72};
      vt[2] = '{1'b0, 1'b1, 1'b0, 4'd1, 8'd1, 8'h96, 8'hC3, 4'b1101, 36};
      vt[3] = '{1'b1, 1'b0, 1'b1, 4'd3, 8'd2, 8'h0F, 8'hE1, 4'b0111, 54};
      vt[4] = '{1'b0, 1'b0, 1'b0, 4'd7, 8'd0, 8'hFF, 8'h55, 4'b1111, 18};

      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("rst_ss_n", ss_n, 4'hF);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_out_data", out_data, 0);
      rd_reg(2'b01, d); chk("rst_status", d, 0);
      rd_reg(2'b00, d); chk("rst_rx", d, 0);
      rd_reg(2'b10, d); chk("rst_div", d, 0);
      rd_reg(2'b11, d); chk("rst_ctrl", d, 0);

      wr_reg(2'b11, 8'h00);
      wr_reg(2'b10, 8'h00);
      miso = 1'b1;
      wr_reg(2'b00, 8'hA5);
      pv = sclk; n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sclk !== pv) begin n++; pv = sclk; end
         if (n == 5) break;
      end
      chk("abort_edge_wait", n, 5);
      rst = 1'b1; cs = 1'b1; rd = 1'b1; addr = 2'b01;
      #1;
      chk("abort_ss_n", ss_n, 4'hF);
      chk("abort_sclk", sclk, 0);
      chk("abort_mosi", mosi, 0);
      chk("abort_status", out_data, 0);
      cs = 1'b0; rd = 1'b0;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      rd_reg(2'b00, d); chk("abort_rx", d, 0);

      for (int i = 0; i < 5; i++) begin
         start(vt[i], 1'b0);
         finish_xfer(0);
      end

      w = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd3, 8'h6B, 8'h2D, 4'b1110, 72};
      start(w, 1'b0);
      wr_reg(2'b00, 8'h11);
      rd_reg(2'b01, d); chk("wcol_status", d, 8'h05);
      rd_reg(2'b01, d); chk("wcol_cleared", d, 8'h01);
      wr_reg(2'b10, 8'h07);
      finish_xfer(4);
      rd_reg(2'b10, d); chk("div_unchanged", d, 8'h03);

`ifdef SPI_LOOPBACK_EN
      w = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'hC3, 8'h00, 4'b1110, 18};
      start(w, 1'b1);
      finish_xfer(0);
      wr_reg(2'b11, 8'h7F);
      rd_reg(2'b11, d); chk("ctrl_readback", d, 8'h7F);
`else
      wr_reg(2'b11, 8'h7F);
      rd_reg(2'b11, d); chk("ctrl_readback", d, 8'h77);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
